uart_tx_framer: RTL
===================

# uart_tx_framer

Parametrised UART transmit framer that turns a parallel word into a complete serial frame: start bit, 1..DATA_WIDTH data bits, optional parity, and one or two stop bits. It sits between the TX holding logic and the TX pin. It is paced by an external one-cycle baud `tick` and takes words over a valid/ready handshake. Successive frames go out back-to-back with no idle gap.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame (≥2).
- LEN_W, $clog2(DATA_WIDTH+1): width of `cfg_len`.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- tick  input  1  baud enable, one-cycle pulse per bit period.
- in_data  input  DATA_WIDTH  word to send; only bits [cfg_len-1:0] are used.
- in_valid  input  1  word available.
- in_ready  output  1  framer accepts a word this cycle.
- cfg_len  input  LEN_W  data bits per frame (1..DATA_WIDTH); 0 or >DATA_WIDTH means DATA_WIDTH.
- cfg_par_en  input  1  append parity bit.
- cfg_par_odd  input  1  1 = odd parity, 0 = even parity.
- cfg_two_stop  input  1  two stop bits.
- cfg_msb_first  input  1  1 = MSB of the used field first, 0 = LSB first.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse when the final stop bit completes.

## Operation
- States:
  - IDLE: tx=1.
  - ARMED: word latched, tx=1, waiting for the first tick.
  - START: tx=0.
  - DATA: data bits in order.
  - PARITY: parity bit.
  - STOP: tx=1.
- Handshake: a transfer occurs when in_valid && in_ready on a rising edge.
  - in_ready = (state==IDLE) || (state==STOP && last stop bit && tick).
  - A word offered while in_ready=0 is held off and is not dropped.
- At transfer, the framer latches in_data, the clamped cfg_len, and all cfg_* inputs. Config changes mid-frame have no effect.
- Parity is computed at transfer as the XOR of the used bits, inverted when cfg_par_odd=1.
- Transitions on tick:
  - ARMED→START.
  - START→DATA (bit index 0).
  - In DATA, the index increments; after bit len-1 go to PARITY if enabled, otherwise STOP.
  - PARITY→STOP.
  - STOP: with cfg_two_stop, the first tick advances a stop counter. On the terminating tick go to IDLE, or go directly to START if a transfer occurs on that cycle.
- A transfer in IDLE goes to ARMED regardless of tick.
- When not in IDLE, tick has no effect except to advance the state as listed. In IDLE, tick is ignored.
- Bit select: LSB-first uses data[idx]; MSB-first uses data[len-1-idx].
- The index counter is LEN_W bits wide and never wraps past len-1.

## Timing
- Reset values: tx=1, busy=0, frame_done=0, in_ready=1 (state IDLE), counters 0. Reset is effective immediately mid-frame and the line returns high.
- tx is registered and updates on the clk edge where tick is sampled. Each bit lasts exactly one tick period.
- Start latency:
  - From a transfer in IDLE, the start bit appears on the edge of the first tick after the transfer.
  - From a transfer on a terminating tick, the start bit appears on the same edge, so there is zero gap.
- frame_done is high for the one cycle after the terminating tick edge (registered), even when a new frame begins.
- busy rises on the edge after the transfer. It falls with the return to IDLE and stays high across back-to-back frames.
- Frame length in ticks: 1 + len + par_en + (1 + two_stop).

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, ARMED, START, DATA, PARITY, STOP);
  - the parity-mode constants;
  - a function for the cfg_len clamp, reused by the RX side.
- One sub-module, `uart_parity_calc`: combinational masked XOR over DATA_WIDTH bits with a len input and an odd/even input. It is shared with the receiver checker.

## Test plan
- Basic LSB-first: DATA_WIDTH=8, len=8, no parity, 1 stop, 0xA5, tick every 16 clk → tx = 0,1,0,1,0,0,1,0,1,1, each bit 16 clk. One frame_done pulse.
- Parity: 0x07, len=8:
  - even parity → parity bit 1;
  - odd parity → 0;
  - 0x00 with even parity → 0.
- Short MSB-first: len=5, cfg_msb_first=1, 0x13 → 0,1,0,0,1,1,1. Upper data bits are ignored.
- Back-to-back: in_valid held with 0x55 then 0x0F, two stop bits:
  - the second start bit follows the second stop bit with no idle tick;
  - busy stays high throughout;
  - frame_done pulses twice.
- Clamp: cfg_len=0 → 8 data bits sent.
- Reset: rst low mid-DATA → tx=1 and busy=0 immediately. A subsequent 0x3C frame is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and data-length clamp
package uart_pkg;
   typedef enum logic [2:0] {IDLE, ARMED, START, DATA, PARITY, STOP} tx_state_e;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   // Zero or oversize lengths fall back to the full data width
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len == 0 || len > max_len) ? max_len : len;
   endfunction
endpackage

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: valid/ready word handshake into the TX framer
interface uart_tx_framer_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   modport master(output in_data, in_valid, input in_ready);
   modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: parity over the low len_i bits of a word, even or odd
module uart_parity_calc import uart_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [LEN_W-1:0]      len_i,
   input  logic                  odd_i,
   output logic                  par_o
);
   logic [DATA_WIDTH-1:0] mask;
   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
      assign mask[i] = LEN_W'(i) < len_i;
   end
   assign par_o = (odd_i == PAR_ODD) ^ (^(data_i & mask));
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: tick-paced UART frame serialiser with start, data, parity and stop bits
module uart_tx_framer import uart_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   uart_tx_framer_if.slave  in_if,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_par_en,
   input  logic             cfg_par_odd,
   input  logic             cfg_two_stop,
   input  logic             cfg_msb_first,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);
   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, shifted;
   logic [LEN_W-1:0]      len_q, idx_q, idx_d, len_c, sel;
   logic                  par_en_q, par_bit_q, two_stop_q, msb_q;
   logic                  stop_q, stop_d, tx_q, tx_d, done_q, done_d;
   logic                  par_c, xfer, last_stop, last_bit;

   assign len_c     = LEN_W'(clamp_len(32'(cfg_len), DATA_WIDTH));
   assign last_stop = !two_stop_q || stop_q;
   assign last_bit  = idx_q == len_q - LEN_W'(1);
   assign in_if.in_ready = state_q == IDLE || (state_q == STOP && last_stop && tick);
   assign xfer      = in_if.in_valid && in_if.in_ready;
   assign busy       = state_q != IDLE;
   assign tx         = tx_q;
   assign frame_done = done_q;

   uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH), .LEN_W(LEN_W)) u_par (
      .data_i(in_if.in_data),
      .len_i (len_c),
      .odd_i (cfg_par_odd),
      .par_o (par_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
      end
   end

   always_comb begin
      case (state_q)
         IDLE:    state_d = xfer ? ARMED : IDLE;
         ARMED:   state_d = tick ? START : ARMED;
         START:   state_d = tick ? DATA : START;
         DATA:    state_d = !(tick && last_bit) ? DATA : par_en_q ? PARITY : STOP;
         PARITY:  state_d = tick ? STOP : PARITY;
         STOP:    state_d = !(tick && last_stop) ? STOP : xfer ? START : IDLE;
         default: state_d = IDLE;
      endcase
      idx_d  = (state_q == DATA && !(tick && last_bit)) ? idx_q + LEN_W'(tick) : '0;
      stop_d = (state_q == STOP && !(tick && last_stop)) ? (stop_q | tick) : 1'b0;
   end

   // The line value is derived from the next state so tx changes on the tick edge itself
   always_comb begin
      sel     = msb_q ? len_q - LEN_W'(1) - idx_d : idx_d;
      shifted = data_q >> sel;
      tx_d    = state_d == START  ? 1'b0 :
                state_d == DATA   ? shifted[0] :
                state_d == PARITY ? par_bit_q : 1'b1;
      done_d  = state_q == STOP && tick && last_stop;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         data_q     <= '0;
         len_q      <= LEN_W'(DATA_WIDTH);
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         two_stop_q <= 1'b0;
         msb_q      <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         done_q <= done_d;
         if (xfer) begin
            data_q     <= in_if.in_data;
            len_q      <= len_c;
            par_en_q   <= cfg_par_en;
            par_bit_q  <= par_c;
            two_stop_q <= cfg_two_stop;
            msb_q      <= cfg_msb_first;
         end
      end
   end
endmodule
